mcp_next_pc_unit: RTL and testbench
===================================

Name: mcp_next_pc_unit

Overview:
- Program-counter register and next-PC formation for the multicycle MIPS core.
- Splices jump targets with parametrised upper-bit and shift widths, and selects sequential, branch, jump or jump-register sources under control-FSM enable.
- Maintains a return-address stack (RAS) with JR prediction-hit reporting.
- Sits between the control FSM / ALU and the instruction-memory address mux.

Parameters:
- WL, 32, datapath/address width
- UPPER_W, 4, upper bits of the jump target taken from seq_pc
- SHIFT, 2, zero bits appended below the instruction index; index width is WL-UPPER_W-SHIFT
- DEPTH, 4, RAS entries (power of two, ≥2)
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_en  in  1  commit next PC this cycle (PCWrite or resolved branch)
- pc_src  in  2  0 seq, 1 branch, 2 jump splice, 3 jump register
- seq_pc  in  WL  PC+4 from ALU
- branch_tgt  in  WL  registered branch target
- instr  in  WL  instruction register
- jr_addr  in  WL  rs register value
- link  in  1  push seq_pc on RAS at commit (JAL/JALR)
- ret  in  1  pop RAS at commit (JR $ra)
- clr_flags  in  1  clear sticky flags
- pc  out  WL  current PC
- ras_top  out  WL  top RAS entry (0 when empty)
- ras_valid  out  1  RAS non-empty
- ret_hit  out  1  one-cycle pulse: popped entry equalled jr_addr
- ras_ovf  out  1  sticky overflow
- ras_unf  out  1  sticky underflow
- misalign  out  1  sticky misaligned target

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, RAS empty, ras_top=0, ras_valid=0, ret_hit=0, all sticky flags 0. Reset mid-operation discards any pending commit.
- Jump splice target = {seq_pc[WL-1:WL-UPPER_W], instr[WL-UPPER_W-SHIFT-1:0], SHIFT zeros}.
- next = mux(pc_src): seq_pc / branch_tgt / splice / jr_addr.
- Commit occurs only when pc_en=1; pc updates on the next rising edge (latency 1). With pc_en=0, PC, RAS and flags (except clr) hold.
- Alignment: if next[1:0]≠0 at commit, pc loads next with bits [1:0] cleared and misalign is set.
- RAS is circular with pointer and count:
  - Push (link=1 at commit): stores seq_pc. When full, it overwrites the oldest entry, count stays DEPTH, and ras_ovf is set.
  - Pop (ret=1 at commit): when non-empty, count decrements and ret_hit pulses the next cycle iff the popped entry equals jr_addr. When empty, ras_unf is set, there is no change, and ret_hit=0.
  - link and ret together (JALR through $ra): pop then push, so the top is replaced and count is unchanged; ret_hit is evaluated against the old top. This never sets ras_ovf. If the stack is empty it sets ras_unf and pushes.
- link/ret are ignored when pc_en=0.
- clr_flags clears ras_ovf, ras_unf and misalign. A set condition in the same cycle wins.
- ret_hit is a registered single-cycle pulse.

Optional Feature:
- MCP_JUMP_STATS_EN defined: adds outputs jump_cnt[15:0] and hit_cnt[15:0].
  - jump_cnt counts commits with pc_src∈{2,3}.
  - hit_cnt counts ret_hit pulses.
  - Both saturate at 16'hFFFF, reset to 0 on rst_n, and clear on clr_flags (clear wins over increment).
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Shared package mcp_pkg holds:
  - pc_src encodings PC_SEQ=0, PC_BR=1, PC_JMP=2, PC_JR=3
  - the 32-bit RESET_PC default
  - the alignment mask constant
- One sub-module: mcp_ras (DEPTH×WL circular stack with push/pop/top/count/ovf/unf). Next-PC muxing and splice stay in the top.

Test Plan:
- Reset with RESET_PC=32'h0040_0000 → pc=32'h0040_0000, ras_valid=0. Commit seq_pc=32'h0040_0004, pc_src=0 → pc=32'h0040_0004 next edge. Repeat with pc_en=0 → pc holds.
- Jump splice: seq_pc=32'hA000_0010, instr=32'h0812_3456, pc_src=2 → pc=32'hA048_D158 (default UPPER_W=4, SHIFT=2).
- JAL then JR: link with seq_pc=32'h0000_0108 → ras_top=32'h0000_0108. ret with jr_addr=32'h0000_0108 → ret_hit pulse, ras_valid=0. Second ret → ras_unf=1, ret_hit=0.
- Overflow: 5 pushes of values 1..5 (×4) with DEPTH=4 → ras_ovf=1. Pops return 20,16,12,8, then underflow.
- Misaligned JR: jr_addr=32'h0000_0102 → pc=32'h0000_0100, misalign=1. clr_flags → misalign=0. clr_flags coincident with a new misaligned commit → misalign stays 1.
- Async reset asserted mid-cycle after pushes, with pc_en=1 held → pc=RESET_PC immediately, RAS empty, flags 0. With MCP_JUMP_STATS_EN, jump_cnt=0.

Source files
------------

// File: rtl/mcp_pkg.sv
// Shared definitions for the multicycle MIPS next-PC unit.
// pc_src encodings, reset PC default, alignment mask and a saturating helper.
package mcp_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_JMP = 2'd2,
        PC_JR  = 2'd3
    } pc_src_e;

    localparam logic [31:0] MCP_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mcp_ras.sv
// Circular return-address stack with sticky overflow/underflow flags.
// Pop+push in one cycle replaces the top entry without moving the pointer.
module mcp_ras
    import mcp_pkg::*;
#(
    parameter int WL    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clr,
    input  logic [WL-1:0] din,
    output logic [WL-1:0] top,
    output logic          valid,
    output logic          ovf,
    output logic          unf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WL-1:0] mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] tp;
    logic [CW-1:0] cnt;
    logic          empty;
    logic          full;
    logic          ovf_evt;
    logic          unf_evt;

    assign tp      = wp - PW'(1);
    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign valid   = !empty;
    assign top     = empty ? '0 : mem[tp];
    // A combined pop+push never grows the stack, so it cannot overflow.
    assign ovf_evt = push && !pop && full;
    assign unf_evt = pop && empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && pop && !empty) begin
                mem[tp] <= din;
            end else if (push) begin
                mem[wp] <= din;
                wp      <= wp + PW'(1);
                if (!full) begin
                    cnt <= cnt + CW'(1);
                end
            end else if (pop && !empty) begin
                wp  <= tp;
                cnt <= cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (ovf_evt) begin
                ovf <= 1'b1;
            end else if (clr) begin
                ovf <= 1'b0;
            end
            if (unf_evt) begin
                unf <= 1'b1;
            end else if (clr) begin
                unf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mcp_next_pc_unit.sv
// PC register, next-PC mux with jump splice, and RAS with JR hit reporting.
// Define MCP_JUMP_STATS_EN to add the jump_cnt/hit_cnt statistics outputs.
module mcp_next_pc_unit
    import mcp_pkg::*;
#(
    parameter int          WL       = 32,
    parameter int          UPPER_W  = 4,
    parameter int          SHIFT    = 2,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = MCP_RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pc_en,
    input  logic [1:0]    pc_src,
    input  logic [WL-1:0] seq_pc,
    input  logic [WL-1:0] branch_tgt,
    input  logic [WL-1:0] instr,
    input  logic [WL-1:0] jr_addr,
    input  logic          link,
    input  logic          ret,
    input  logic          clr_flags,
    output logic [WL-1:0] pc,
    output logic [WL-1:0] ras_top,
    output logic          ras_valid,
    output logic          ret_hit,
    output logic          ras_ovf,
    output logic          ras_unf,
    output logic          misalign
`ifdef MCP_JUMP_STATS_EN
    ,
    output logic [15:0]   jump_cnt,
    output logic [15:0]   hit_cnt
`endif
);

    logic [WL-1:0] upper_mask;
    logic [WL-1:0] amask;
    logic [WL-1:0] splice;
    logic [WL-1:0] next;
    logic          push;
    logic          pop;
    logic          mis_evt;
    logic          hit_d;

    assign upper_mask = ~({WL{1'b1}} >> UPPER_W);
    assign amask      = ALIGN_MASK[WL-1:0];

    // Index field shifted up; masking drops instr bits beyond the index width.
    assign splice = (seq_pc & upper_mask)
                  | ((instr << SHIFT) & ~upper_mask);

    always_comb begin
        next = seq_pc;
        unique case (pc_src)
            PC_SEQ: next = seq_pc;
            PC_BR:  next = branch_tgt;
            PC_JMP: next = splice;
            PC_JR:  next = jr_addr;
        endcase
    end

    assign push    = pc_en && link;
    assign pop     = pc_en && ret;
    assign mis_evt = pc_en && ((next & ~amask) != '0);
    assign hit_d   = pop && ras_valid && (ras_top == jr_addr);

    mcp_ras #(
        .WL    (WL),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clr   (clr_flags),
        .din   (seq_pc),
        .top   (ras_top),
        .valid (ras_valid),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC[WL-1:0];
            ret_hit  <= 1'b0;
            misalign <= 1'b0;
        end else begin
            ret_hit <= hit_d;
            if (pc_en) begin
                pc <= next & amask;
            end
            if (mis_evt) begin
                misalign <= 1'b1;
            end else if (clr_flags) begin
                misalign <= 1'b0;
            end
        end
    end

`ifdef MCP_JUMP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_cnt <= '0;
            hit_cnt  <= '0;
        end else if (clr_flags) begin
            jump_cnt <= '0;
            hit_cnt  <= '0;
        end else begin
            if (pc_en && pc_src[1]) begin
                jump_cnt <= sat_inc16(jump_cnt);
            end
            if (ret_hit) begin
                hit_cnt <= sat_inc16(hit_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mcp_next_pc_unit.sv
// Table-driven scoreboard bench for mcp_next_pc_unit.
// Also exercises async reset asserted mid-cycle with a commit pending.
module tb_mcp_next_pc_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    typedef struct {
        logic        en;
        logic [1:0]  src;
        logic [31:0] seq;
        logic [31:0] br;
        logic [31:0] ins;
        logic [31:0] jr;
        logic        lk;
        logic        rt;
        logic        clr;
        logic [31:0] e_pc;
        logic [31:0] e_top;
        logic        e_v;
        logic        e_hit;
        logic        e_ovf;
        logic        e_unf;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] top;
        logic        v;
        logic        hit;
        logic        ovf;
        logic        unf;
        logic        mis;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_en = 1'b0;
    logic [1:0]  pc_src = 2'd0;
    logic [31:0] seq_pc = '0;
    logic [31:0] branch_tgt = '0;
    logic [31:0] instr = '0;
    logic [31:0] jr_addr = '0;
    logic        link = 1'b0;
    logic        ret = 1'b0;
    logic        clr_flags = 1'b0;
    logic [31:0] pc;
    logic [31:0] ras_top;
    logic        ras_valid;
    logic        ret_hit;
    logic        ras_ovf;
    logic        ras_unf;
    logic        misalign;
`ifdef MCP_JUMP_STATS_EN
    logic [15:0] jump_cnt;
    logic [15:0] hit_cnt;
`endif

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];
    obs_t sb[$];

    always #5 clk = ~clk;

    mcp_next_pc_unit #(
        .WL       (32),
        .UPPER_W  (4),
        .SHIFT    (2),
        .DEPTH    (4),
        .RESET_PC (RPC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .seq_pc     (seq_pc),
        .branch_tgt (branch_tgt),
        .instr      (instr),
        .jr_addr    (jr_addr),
        .link       (link),
        .ret        (ret),
        .clr_flags  (clr_flags),
        .pc         (pc),
        .ras_top    (ras_top),
        .ras_valid  (ras_valid),
        .ret_hit    (ret_hit),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf),
        .misalign   (misalign)
`ifdef MCP_JUMP_STATS_EN
        ,
        .jump_cnt   (jump_cnt),
        .hit_cnt    (hit_cnt)
`endif
    );

    task automatic add(
        input logic en, input logic [1:0] src,
        input logic [31:0] seq, input logic [31:0] br,
        input logic [31:0] ins, input logic [31:0] jr,
        input logic lk, input logic rt, input logic clr,
        input logic [31:0] e_pc, input logic [31:0] e_top,
        input logic e_v, input logic e_hit, input logic e_ovf,
        input logic e_unf, input logic e_mis);
        vec_t v;
        v = '{en, src, seq, br, ins, jr, lk, rt, clr,
              e_pc, e_top, e_v, e_hit, e_ovf, e_unf, e_mis};
        vecs.push_back(v);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o = '{pc, ras_top, ras_valid, ret_hit, ras_ovf, ras_unf, misalign};
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t a;
        a = sample();
        checks++;
        if (a !== exp) begin
            failures++;
            $display("FAIL %s: got pc=%h top=%h v=%b hit=%b ovf=%b unf=%b mis=%b want pc=%h top=%h v=%b hit=%b ovf=%b unf=%b mis=%b",
                     name, a.pc, a.top, a.v, a.hit, a.ovf, a.unf, a.mis,
                     exp.pc, exp.top, exp.v, exp.hit, exp.ovf, exp.unf, exp.mis);
        end
    endtask

    task automatic drive(input vec_t v);
        pc_en      = v.en;
        pc_src     = v.src;
        seq_pc     = v.seq;
        branch_tgt = v.br;
        instr      = v.ins;
        jr_addr    = v.jr;
        link       = v.lk;
        ret        = v.rt;
        clr_flags  = v.clr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        obs_t e;
        // en src seq br ins jr lk rt clr | pc top v hit ovf unf mis
        add(1, 0, 32'h0040_0004, 0, 0, 0, 0, 0, 0, 32'h0040_0004, 0, 0, 0, 0, 0, 0);
        add(0, 0, 32'h0040_0008, 0, 0, 0, 0, 0, 0, 32'h0040_0004, 0, 0, 0, 0, 0, 0);
        add(0, 2, 32'h0000_0100, 0, 0, 0, 1, 1, 0, 32'h0040_0004, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 32'h0040_0040, 0, 0, 0, 0, 0, 32'h0040_0040, 0, 0, 0, 0, 0, 0);
        add(1, 2, 32'hA000_0010, 0, 32'h0812_3456, 0, 0, 0, 0, 32'hA048_D158, 0, 0, 0, 0, 0, 0);
        add(1, 2, 32'h0000_0108, 0, 32'h0000_0040, 0, 1, 0, 0, 32'h0000_0100, 32'h108, 1, 0, 0, 0, 0);
        add(1, 3, 0, 0, 0, 32'h0000_0108, 0, 1, 0, 32'h0000_0108, 0, 0, 1, 0, 0, 0);
        add(1, 3, 0, 0, 0, 32'h0000_0108, 0, 1, 0, 32'h0000_0108, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0108, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            add(1, 0, 32'(k * 4), 0, 0, 0, 1, 0, 0, 32'(k * 4), 32'(k * 4), 1, 0, (k == 5), 0, 0);
        end
        add(1, 3, 0, 0, 0, 32'd20, 0, 1, 0, 32'd20, 32'd16, 1, 1, 1, 0, 0);
        add(1, 3, 0, 0, 0, 32'd16, 0, 1, 0, 32'd16, 32'd12, 1, 1, 1, 0, 0);
        add(1, 3, 0, 0, 0, 32'd12, 0, 1, 0, 32'd12, 32'd8, 1, 1, 1, 0, 0);
        add(1, 3, 0, 0, 0, 32'd8, 0, 1, 0, 32'd8, 0, 0, 1, 1, 0, 0);
        add(1, 3, 0, 0, 0, 32'h200, 0, 1, 0, 32'h200, 0, 0, 0, 1, 1, 0);
        add(1, 0, 32'h300, 0, 0, 0, 1, 0, 0, 32'h300, 32'h300, 1, 0, 1, 1, 0);
        add(1, 3, 0, 0, 0, 32'h304, 0, 1, 0, 32'h304, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h304, 0, 0, 0, 0, 0, 0);
        add(1, 3, 0, 0, 0, 32'h102, 0, 0, 0, 32'h100, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
        add(1, 3, 0, 0, 0, 32'h203, 0, 0, 1, 32'h200, 0, 0, 0, 0, 0, 1);
        add(1, 0, 32'h400, 0, 0, 0, 1, 0, 0, 32'h400, 32'h400, 1, 0, 0, 0, 1);
        add(1, 3, 32'h404, 0, 0, 32'h400, 1, 1, 0, 32'h400, 32'h404, 1, 1, 0, 0, 1);
        add(1, 3, 0, 0, 0, 32'h404, 0, 1, 0, 32'h404, 0, 0, 1, 0, 0, 1);
        add(1, 0, 32'h408, 0, 0, 32'h408, 1, 1, 0, 32'h408, 32'h408, 1, 0, 0, 1, 1);
        add(0, 1, 0, 32'h501, 0, 0, 0, 0, 0, 32'h408, 32'h408, 1, 0, 0, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        check("reset", '{RPC, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            sb.push_back('{vecs[i].e_pc, vecs[i].e_top, vecs[i].e_v,
                           vecs[i].e_hit, vecs[i].e_ovf, vecs[i].e_unf,
                           vecs[i].e_mis});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d", i), e);
        end

        // Async reset mid-cycle with a link commit held pending.
        @(negedge clk);
        drive('{1, 0, 32'h0000_0999, 0, 0, 0, 1, 0, 0,
                0, 0, 0, 0, 0, 0, 0});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", '{RPC, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
`ifdef MCP_JUMP_STATS_EN
        checks++;
        if (jump_cnt !== 16'd0) begin
            failures++;
            $display("FAIL jump_cnt_rst: got %h want 0000", jump_cnt);
        end
`endif
        @(posedge clk);
        #1;
        check("rst_hold", '{RPC, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        seq_pc = 32'h0000_0994;
        @(posedge clk);
        #1;
        check("post_rst", '{32'h994, 32'h994, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        pc_en = 1'b0;
        link = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
